spi_xfer_seq: RTL and testbench
===============================

SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8'd1, the value written to per_spi ctrl[15:8].
REQ-002 SHALL have parameter CPOL, default 1'b0, the value written to ctrl[1].
REQ-003 SHALL have parameter CPHA, default 1'b0, the value written to ctrl[2].
REQ-004 clk_i  in  1  single clock; all logic on the rising edge.
REQ-005 rst_i_n  in  1  reset, synchronous, active-low.
REQ-006 req_valid_i / req_ready_o  in/out  1/1  request handshake; a request is accepted when both are 1.
REQ-007 cmd_i  in  8  command byte. addr_i  in  24  address. len_i  in  8  number of read bytes (0 = none).
REQ-008 rd_valid_o / rd_ready_i / rd_data_o  out/in/out  1/1/8  read-byte stream.
REQ-009 busy_o  out  1  high from request accept until return to IDLE.
REQ-010 spi_wr_o, spi_rd_o  out  1 each  register-port strobes to per_spi.
REQ-011 spi_addr_o  out  32  register address to per_spi.
REQ-012 spi_wdata_o  out  32  register write data to per_spi.
REQ-013 spi_size_o  out  2  access size to per_spi; constant 2'b10.
REQ-014 spi_rdata_i  in  32  combinational read data from per_spi.

Function
REQ-015 SHALL raise req_ready_o only in IDLE, and SHALL latch cmd_i, addr_i and len_i on accept.
REQ-016 SHALL shift bytes in this order: cmd, addr[23:16], addr[15:8], addr[7:0], then len_i dummy 0x00 bytes; the total is 4+len_i bytes.
REQ-017 SHALL use the states IDLE -> CS_ON -> LOAD -> START -> HOLD -> POLL -> FETCH -> (PUSH) -> LOAD | CS_OFF -> IDLE.
- CS_ON: write addr 0x0, wdata = {16'h0, CLK_DIV, 4'b1000, 0, CPHA, CPOL, 0}.
- LOAD: write addr 0x4 with {24'h0, byte}.
- START: write addr 0x0 with the CS_ON value OR 1 (enable).
- HOLD: no strobe for exactly 3 cycles.
- POLL: spi_rd_o=1 at addr 0x8; sample spi_rdata_i[0] in the same cycle; stay while it is 1, go to FETCH when it is 0.
- FETCH: spi_rd_o=1 at addr 0x4; capture spi_rdata_i[7:0].
REQ-018 SHALL discard the bytes captured during the cmd and addr phases, and SHALL pass the bytes of the dummy phase through PUSH into the read buffer.
REQ-019 PUSH SHALL wait while the buffer is full; it SHALL NOT start the next byte until the current byte is stored.
REQ-020 CS_OFF SHALL write addr 0x0 with 32'h0 (deasserts slave select), then go to IDLE.
REQ-021 Outside write/read states, spi_wr_o, spi_rd_o, spi_addr_o and spi_wdata_o SHALL be 0; at most one strobe SHALL be active per cycle.
REQ-022 The byte counter SHALL be 9 bits wide with no wrap; len_i=255 SHALL yield 259 bytes.
REQ-023 rd_valid_o SHALL be high while the buffer is non-empty; a byte is popped when rd_valid_o and rd_ready_i are both 1.
REQ-024 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-025 The buffer SHALL persist across IDLE, so unread bytes remain available after busy_o falls.

Reset
REQ-026 On rst_i_n=0 at a clock edge, state SHALL return to IDLE and the buffer SHALL be emptied.
REQ-027 Reset values SHALL be: req_ready_o=1, busy_o=0, rd_valid_o=0, rd_data_o=0, and all spi_* outputs 0 except spi_size_o.
REQ-028 A reset during a transfer SHALL abort it with no CS_OFF write; per_spi is reset by the same rst_i_n.

Configuration
REQ-029 SHALL use the macro SPI_XFER_SEQ_RBUF_EN to select the read buffer:
- defined: 4-entry FIFO with 2-bit pointers that wrap, full at 4 entries;
- undefined: single 8-bit holding register, full at 1 entry.
All other behaviour SHALL be identical.

Verification
REQ-030 cmd=0x03, addr=0x123456, len=0, per_spi model -> writes to 0x4 carry 0x03, 0x12, 0x34, 0x56 in order; no rd_valid_o; last write is 0x0 <- 0; busy_o falls.
REQ-031 len=3, slave returns 0xA5, 0x5A, 0xFF in the dummy phase, rd_ready_i=1 -> rd_data_o gives 0xA5, 0x5A, 0xFF in order; exactly 7 START writes.
REQ-032 len=6, rd_ready_i=0 -> with RBUF_EN the sequencer stalls in PUSH after 4 bytes; without it, after 1 byte; asserting rd_ready_i completes all 6 bytes in order.
REQ-033 Status bit held at 1 for 50 cycles -> POLL repeats for 50 cycles, with no LOAD write during that time.
REQ-034 rst_i_n=0 during POLL of byte 2 -> next cycle: IDLE, req_ready_o=1, rd_valid_o=0; a new request then completes normally.

Source files
------------

// File: rtl/spi_xfer_seq.sv
// SPI transfer sequencer: drives per_spi registers to shift cmd/addr/dummy bytes and streams dummy-phase read bytes out.
// Build option SPI_XFER_SEQ_RBUF_EN selects a 4-entry read FIFO; otherwise a single holding register is used.
module spi_xfer_seq #(
  parameter logic [7:0] CLK_DIV = 8'd1,
  parameter logic       CPOL    = 1'b0,
  parameter logic       CPHA    = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  cmd_i,
  input  logic [23:0] addr_i,
  input  logic [7:0]  len_i,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic [7:0]  rd_data_o,
  output logic        busy_o,
  output logic        spi_wr_o,
  output logic        spi_rd_o,
  output logic [31:0] spi_addr_o,
  output logic [31:0] spi_wdata_o,
  output logic [1:0]  spi_size_o,
  input  logic [31:0] spi_rdata_i
);

  localparam logic [31:0] CTRL_CFG = {16'h0, CLK_DIV, 4'b1000, 1'b0, CPHA, CPOL, 1'b0};

  typedef enum logic [3:0] {
    S_IDLE, S_CS_ON, S_LOAD, S_START, S_HOLD, S_POLL, S_FETCH, S_PUSH, S_CS_OFF
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cmd_reg, len_reg;
  logic [23:0] addr_reg;
  logic [8:0]  cnt_reg, cnt_next;
  logic [1:0]  hold_reg, hold_next;
  logic [7:0]  rx_reg, rx_next;
  logic [7:0]  tx_byte;
  logic        last_byte, dummy_phase;
  logic        push, pop, buf_full;
  logic        unused_rdata;

  assign unused_rdata = ^spi_rdata_i[31:8];
  assign req_ready_o  = (state_reg == S_IDLE);
  assign busy_o       = (state_reg != S_IDLE);
  assign spi_size_o   = 2'b10;
  assign dummy_phase  = (cnt_reg >= 9'd4);
  assign last_byte    = (cnt_reg == ({1'b0, len_reg} + 9'd3));
  assign pop          = rd_valid_o && rd_ready_i;

  always_comb begin
    tx_byte = 8'h00;
    case (cnt_reg)
      9'd0:    tx_byte = cmd_reg;
      9'd1:    tx_byte = addr_reg[23:16];
      9'd2:    tx_byte = addr_reg[15:8];
      9'd3:    tx_byte = addr_reg[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 9'd0;
      hold_reg  <= 2'd0;
      rx_reg    <= 8'h00;
      cmd_reg   <= 8'h00;
      addr_reg  <= 24'h0;
      len_reg   <= 8'h00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hold_reg  <= hold_next;
      rx_reg    <= rx_next;
      if (req_valid_i && req_ready_o) begin
        cmd_reg  <= cmd_i;
        addr_reg <= addr_i;
        len_reg  <= len_i;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hold_next   = hold_reg;
    rx_next     = rx_reg;
    push        = 1'b0;
    spi_wr_o    = 1'b0;
    spi_rd_o    = 1'b0;
    spi_addr_o  = 32'h0;
    spi_wdata_o = 32'h0;
    case (state_reg)
      S_IDLE: begin
        if (req_valid_i) begin
          state_next = S_CS_ON;
          cnt_next   = 9'd0;
        end
      end
      S_CS_ON: begin
        spi_wr_o    = 1'b1;
        spi_wdata_o = CTRL_CFG;
        state_next  = S_LOAD;
      end
      S_LOAD: begin
        spi_wr_o    = 1'b1;
        spi_addr_o  = 32'h4;
        spi_wdata_o = {24'h0, tx_byte};
        state_next  = S_START;
      end
      S_START: begin
        spi_wr_o    = 1'b1;
        spi_wdata_o = CTRL_CFG | 32'h1;
        hold_next   = 2'd0;
        state_next  = S_HOLD;
      end
      S_HOLD: begin
        // Give per_spi time to raise its busy flag before the first status read.
        if (hold_reg == 2'd2) state_next = S_POLL;
        else                  hold_next  = hold_reg + 2'd1;
      end
      S_POLL: begin
        spi_rd_o   = 1'b1;
        spi_addr_o = 32'h8;
        if (!spi_rdata_i[0]) state_next = S_FETCH;
      end
      S_FETCH: begin
        spi_rd_o   = 1'b1;
        spi_addr_o = 32'h4;
        rx_next    = spi_rdata_i[7:0];
        if (dummy_phase) begin
          state_next = S_PUSH;
        end else if (last_byte) begin
          state_next = S_CS_OFF;
        end else begin
          cnt_next   = cnt_reg + 9'd1;
          state_next = S_LOAD;
        end
      end
      S_PUSH: begin
        if (!buf_full) begin
          push = 1'b1;
          if (last_byte) begin
            state_next = S_CS_OFF;
          end else begin
            cnt_next   = cnt_reg + 9'd1;
            state_next = S_LOAD;
          end
        end
      end
      S_CS_OFF: begin
        spi_wr_o   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

`ifdef SPI_XFER_SEQ_RBUF_EN
  logic [7:0] buf_mem [0:3];
  logic [1:0] wr_ptr_reg, rd_ptr_reg;
  logic [2:0] count_reg;

  assign buf_full   = (count_reg == 3'd4);
  assign rd_valid_o = (count_reg != 3'd0);
  assign rd_data_o  = rd_valid_o ? buf_mem[rd_ptr_reg] : 8'h00;

  always_ff @(posedge clk_i) begin
    if (push) buf_mem[wr_ptr_reg] <= rx_reg;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i_n) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end
`else
  logic [7:0] hold_data_reg;
  logic       hold_full_reg;

  assign buf_full   = hold_full_reg;
  assign rd_valid_o = hold_full_reg;
  assign rd_data_o  = hold_full_reg ? hold_data_reg : 8'h00;

  // push needs an empty register and pop needs a full one, so they never coincide.
  always_ff @(posedge clk_i) begin
    if (!rst_i_n) begin
      hold_data_reg <= 8'h00;
      hold_full_reg <= 1'b0;
    end else if (push) begin
      hold_data_reg <= rx_reg;
      hold_full_reg <= 1'b1;
    end else if (pop) begin
      hold_full_reg <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Scoreboard bench for spi_xfer_seq with a behavioural per_spi register model.
module tb_spi_xfer_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [7:0]  cmd;
  logic [23:0] addr;
  logic [7:0]  len;
  logic        rd_valid, rd_ready, busy;
  logic [7:0]  rd_data;
  logic        spi_wr, spi_rd;
  logic [31:0] spi_addr, spi_wdata, spi_rdata;
  logic [1:0]  spi_size;

  always #5 clk = ~clk;

  spi_xfer_seq dut (
    .clk_i(clk), .rst_i_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .cmd_i(cmd), .addr_i(addr), .len_i(len),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .busy_o(busy),
    .spi_wr_o(spi_wr), .spi_rd_o(spi_rd),
    .spi_addr_o(spi_addr), .spi_wdata_o(spi_wdata),
    .spi_size_o(spi_size), .spi_rdata_i(spi_rdata)
  );

  localparam logic [31:0] CTRL  = 32'h0000_0180;
  localparam logic [31:0] START = 32'h0000_0181;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // per_spi model: status busy for busy_cycles polls after each start, rx byte per dummy slot
  int         busy_cycles = 0;
  int         start_cnt = 0, tot_starts = 0, busy_polls = 0, busy_loads = 0, busy_cnt = 0;
  logic [7:0] rx_data [0:15];
  logic [7:0] cur_byte;

  always_comb begin
    cur_byte = 8'hEE;
    if (start_cnt >= 5) cur_byte = rx_data[start_cnt-5];
  end

  assign spi_rdata = (spi_rd && spi_addr == 32'h8) ? {31'h0, busy_cnt != 0} :
                     (spi_rd && spi_addr == 32'h4) ? {24'h0, cur_byte} : 32'h0;

  always @(posedge clk) begin
    if (!rst_n) begin
      start_cnt <= 0;
      busy_cnt  <= 0;
    end else begin
      if (spi_wr && spi_addr == 32'h0) begin
        if (spi_wdata[0]) begin
          start_cnt  <= start_cnt + 1;
          tot_starts <= tot_starts + 1;
          busy_cnt   <= busy_cycles;
        end else if (spi_wdata != 32'h0) begin
          start_cnt <= 0;
        end
      end
      if (spi_rd && spi_addr == 32'h8 && busy_cnt != 0) begin
        busy_cnt   <= busy_cnt - 1;
        busy_polls <= busy_polls + 1;
      end
      if (spi_wr && spi_addr == 32'h4 && busy_cnt != 0) busy_loads <= busy_loads + 1;
    end
  end

  logic [63:0] exp_wr [$];
  logic [7:0]  exp_rd [$];

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      chk("one_strobe", 64'(spi_wr & spi_rd), 64'h0);
      if (!spi_wr && !spi_rd) chk("idle_bus", {spi_addr, spi_wdata}, 64'h0);
      if (spi_wr) begin
        if (exp_wr.size() == 0) chk("unexpected_write", {spi_addr, spi_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("spi_write", {spi_addr, spi_wdata}, exp_wr.pop_front());
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) chk("unexpected_rd", 64'(rd_data), 64'h1FF);
        else chk("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
      end
    end
  end

  task automatic issue(input logic [7:0] c, input logic [23:0] a, input logic [7:0] l);
    logic [7:0] b;
    logic       got;
    int         n;
    exp_wr.push_back({32'h0, CTRL});
    for (int i = 0; i < int'(l) + 4; i++) begin
      case (i)
        0:       b = c;
        1:       b = a[23:16];
        2:       b = a[15:8];
        3:       b = a[7:0];
        default: b = 8'h00;
      endcase
      exp_wr.push_back({32'h4, 24'h0, b});
      exp_wr.push_back({32'h0, START});
    end
    exp_wr.push_back(64'h0);
    cmd = c; addr = a; len = l; req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      got = req_ready;
      @(posedge clk);
      n++;
    end while (!got && n < 100);
    chk("req_accept", 64'(got), 64'h1);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk("busy_fall", 64'(busy), 64'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("wr_queue_empty", 64'(exp_wr.size()), 64'h0);
    chk("rd_queue_empty", 64'(exp_rd.size()), 64'h0);
  endtask

  initial begin
    int s0, p0, l0, n;
    rst_n = 1'b0; req_valid = 1'b0; cmd = 8'h0; addr = 24'h0; len = 8'h0; rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) rx_data[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_rd_valid", 64'(rd_valid), 64'h0);
    chk("rst_rd_data", 64'(rd_data), 64'h0);
    chk("rst_strobes", 64'({spi_wr, spi_rd}), 64'h0);
    chk("rst_spi_bus", {spi_addr, spi_wdata}, 64'h0);
    chk("rst_spi_size", 64'(spi_size), 64'h2);
    rst_n = 1'b1;

    // len=0: header only
    rd_ready = 1'b1;
    s0 = tot_starts;
    issue(8'h03, 24'h123456, 8'd0);
    wait_idle(500);
    chk("len0_starts", 64'(tot_starts - s0), 64'd4);
    chk("len0_no_rd", 64'(rd_valid), 64'h0);
    $display("txn len0 cmd=03 addr=123456 done");

    // len=3 read stream
    rx_data[0] = 8'hA5; rx_data[1] = 8'h5A; rx_data[2] = 8'hFF;
    exp_rd.push_back(8'hA5); exp_rd.push_back(8'h5A); exp_rd.push_back(8'hFF);
    s0 = tot_starts;
    issue(8'h0B, 24'hABCDEF, 8'd3);
    wait_idle(500);
    chk("len3_starts", 64'(tot_starts - s0), 64'd7);
    $display("txn len3 cmd=0B addr=ABCDEF done");

    // long busy status
    busy_cycles = 50;
    p0 = busy_polls; l0 = busy_loads;
    rx_data[0] = 8'h3C;
    exp_rd.push_back(8'h3C);
    issue(8'h9F, 24'h000001, 8'd1);
    wait_idle(3000);
    chk("busy_polls", 64'(busy_polls - p0), 64'd250);
    chk("no_load_while_busy", 64'(busy_loads - l0), 64'd0);
    busy_cycles = 0;
    $display("txn busy50 len1 done");

    // stall with reader not ready
    rd_ready = 1'b0;
    rx_data[0] = 8'h11; rx_data[1] = 8'h22; rx_data[2] = 8'h33;
    rx_data[3] = 8'h44; rx_data[4] = 8'h55; rx_data[5] = 8'h66;
    for (int i = 0; i < 6; i++) exp_rd.push_back(rx_data[i]);
    s0 = tot_starts;
    issue(8'h03, 24'h00FF00, 8'd6);
    repeat (200) @(posedge clk);
    #1;
`ifdef SPI_XFER_SEQ_RBUF_EN
    chk("stall_starts", 64'(tot_starts - s0), 64'd9);
`else
    chk("stall_starts", 64'(tot_starts - s0), 64'd6);
`endif
    chk("stall_busy", 64'(busy), 64'h1);
    chk("stall_rd_valid", 64'(rd_valid), 64'h1);
    chk("stall_head", 64'(rd_data), 64'h11);
    rd_ready = 1'b1;
    wait_idle(1000);
    $display("txn stall len6 done");

    // unread byte persists after busy falls
    rd_ready = 1'b0;
    rx_data[0] = 8'h77;
    issue(8'h03, 24'h000010, 8'd1);
    wait_idle(500);
    chk("persist_valid", 64'(rd_valid), 64'h1);
    chk("persist_data", 64'(rd_data), 64'h77);
    $display("txn persist len1 done");

    // reset during POLL of byte 2
    busy_cycles = 2;
    issue(8'h05, 24'h0A0B0C, 8'd3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(spi_rd && spi_addr == 32'h8 && start_cnt == 3) && n < 500);
    chk("poll_byte2_reached", 64'(n < 500), 64'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_req_ready", 64'(req_ready), 64'h1);
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_rd_valid", 64'(rd_valid), 64'h0);
    exp_wr.delete();
    exp_rd.delete();
    rst_n = 1'b1;
    busy_cycles = 0;
    $display("txn reset-abort done");

    // normal request after reset
    rd_ready = 1'b1;
    rx_data[0] = 8'hC3; rx_data[1] = 8'h3C;
    exp_rd.push_back(8'hC3); exp_rd.push_back(8'h3C);
    s0 = tot_starts;
    issue(8'h3B, 24'h765432, 8'd2);
    wait_idle(500);
    chk("post_reset_starts", 64'(tot_starts - s0), 64'd6);
    $display("txn post-reset len2 done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
